// File: rtl/serial_compare_sequencer.sv
// Sequencer that feeds an operand pair MSB-first into an external serial comparator
// and captures the comparator's flags after the last bit.
module serial_compare_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_clear,
  output logic             ser_valid,
  output logic             ser_a,
  output logic             ser_b,
  input  logic             cmp_less,
  input  logic             cmp_eq,
  input  logic             cmp_greater,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_less,
  output logic             out_eq,
  output logic             out_greater,
  output logic             out_error
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             less_q, less_d;
  logic             eq_q, eq_d;
  logic             greater_q, greater_d;
  logic             error_q, error_d;
  logic [1:0]       flag_cnt;

  assign flag_cnt = {1'b0, cmp_less} + {1'b0, cmp_eq} + {1'b0, cmp_greater};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    less_d    = less_q;
    eq_d      = eq_q;
    greater_d = greater_q;
    error_d   = error_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = StClear;
        end
      end
      StClear: begin
        cnt_d   = CntLast;
        state_d = StShift;
      end
      StShift: begin
        // Operands shift left so the live bit is always the MSB.
        a_d = a_q << 1;
        b_d = b_q << 1;
        if (cnt_q == '0) begin
          less_d    = cmp_less;
          eq_d      = cmp_eq;
          greater_d = cmp_greater;
          error_d   = (flag_cnt != 2'd1);
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      less_q    <= 1'b0;
      eq_q      <= 1'b0;
      greater_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      less_q    <= less_d;
      eq_q      <= eq_d;
      greater_q <= greater_d;
      error_q   <= error_d;
    end
  end

  // Reset clears the downstream comparator in the same cycles as this block.
  assign ser_clear   = rst | (state_q == StClear);
  assign ser_valid   = (state_q == StShift);
  assign ser_a       = ser_valid & a_q[WIDTH-1];
  assign ser_b       = ser_valid & b_q[WIDTH-1];
  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign out_less    = less_q;
  assign out_eq      = eq_q;
  assign out_greater = greater_q;
  assign out_error   = error_q;

endmodule

// File: doc/serial_compare_sequencer.md
SERIAL_COMPARE_SEQUENCER -- requirements
Module: serial_compare_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; the block SHALL support any WIDTH >= 1.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset; it SHALL be synchronous and active-high.
REQ-004 in_valid  input  1  parallel operand pair is offered.
REQ-005 in_ready  output  1  the block accepts an operand pair this cycle.
REQ-006 in_a  input  WIDTH  operand A, unsigned.
REQ-007 in_b  input  WIDTH  operand B, unsigned.
REQ-008 ser_clear  output  1  clear strobe to the downstream MSB-first serial comparator's reset.
REQ-009 ser_valid  output  1  ser_a and ser_b carry a live bit this cycle.
REQ-010 ser_a  output  1  current bit of A, MSB first.
REQ-011 ser_b  output  1  current bit of B, MSB first.
REQ-012 cmp_less  input  1  comparator a_less_b flag (combinational, same cycle as the bit).
REQ-013 cmp_eq  input  1  comparator a_eq_b flag.
REQ-014 cmp_greater  input  1  comparator a_greater_b flag.
REQ-015 out_valid  output  1  result is held and valid.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 out_less  output  1  captured result: A < B.
REQ-018 out_eq  output  1  captured result: A == B.
REQ-019 out_greater  output  1  captured result: A > B.
REQ-020 out_error  output  1  the captured flags were not exactly one-hot.

Function
REQ-021 The FSM SHALL have four states: IDLE, CLEAR, SHIFT, DONE.
REQ-022 IDLE: in_ready=1. When in_valid=1, the block SHALL latch in_a/in_b into shift registers and go to CLEAR; otherwise it SHALL stay in IDLE.
REQ-023 CLEAR lasts one cycle: ser_clear=1, ser_valid=0, then go to SHIFT with bit counter = WIDTH-1.
REQ-024 SHIFT lasts exactly WIDTH cycles: ser_valid=1, ser_a/ser_b = A[k]/B[k] with k running WIDTH-1 down to 0, decrementing one per cycle.
REQ-025 In the SHIFT cycle with k=0, the block SHALL register cmp_less/cmp_eq/cmp_greater into out_less/out_eq/out_greater, set out_error = NOT(exactly one flag high), then go to DONE.
REQ-026 DONE: out_valid=1 and results held stable until out_ready=1; on that cycle the block SHALL go to IDLE, and out_valid SHALL be 0 on the next cycle.
REQ-027 in_ready SHALL be 0 in CLEAR, SHIFT and DONE; in_valid SHALL be ignored in those states.
REQ-028 Whenever ser_valid=0, ser_a and ser_b SHALL be 0.
REQ-029 The cmp_* inputs SHALL be sampled only in the k=0 SHIFT cycle and ignored otherwise.
REQ-030 Latency from the accept cycle to the first out_valid cycle SHALL be WIDTH+2 cycles; minimum spacing between accepts SHALL be WIDTH+3 cycles.
REQ-031 WIDTH=1: SHIFT SHALL last one cycle, and that cycle is also the capture cycle.
REQ-032 Out-of-state condition: if the FSM reaches an illegal encoding, it SHALL return to IDLE on the next edge.

Reset
REQ-033 While rst=1, ser_clear SHALL be 1, so the downstream comparator is cleared together with this block.
REQ-034 After the rst edge: state=IDLE, in_ready=1, out_valid=0, ser_valid=0, ser_a=ser_b=0, out_less=out_eq=out_greater=out_error=0, counter=0.
REQ-035 rst asserted in any state, including mid-SHIFT or DONE, SHALL abort the transaction with no result emitted.

Verification (WIDTH=8)
REQ-036 A=0x5A, B=0x5A, out_ready=1 -> ser_a sequence 0,1,0,1,1,0,1,0; out_valid on cycle accept+10; out_eq=1, out_error=0.
REQ-037 A=0x80, B=0x7F -> first SHIFT cycle ser_a=1, ser_b=0; result out_greater=1. A=0x00, B=0xFF -> out_less=1.
REQ-038 Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid and flags held constant, in_ready=0 throughout; release -> IDLE, then the next pair is accepted.
REQ-039 rst pulsed on the 4th SHIFT cycle -> next cycle is IDLE with all outputs at reset values, and no out_valid follows; a new pair then completes normally.
REQ-040 Bench model drives cmp_less=cmp_greater=1 at k=0 -> out_error=1; back-to-back in_valid held high -> accepts spaced exactly 11 cycles apart.
